// File: rtl/trace_event_sampler_pkg.sv
// Shared constants for the trace event sampler and the downstream checker.
// Event word layout is {time, vec}; its width is ev_w(TS_W).
package trace_event_sampler_pkg;

  localparam int EV_VEC_W = 4;
  localparam int DROP_W   = 8;

  function automatic int ev_w(int ts_w);
    return ts_w + EV_VEC_W;
  endfunction

endpackage

// File: rtl/trace_event_sampler_if.sv
// Event stream from sampler to checker: FIFO head plus valid/ready.
// A pop happens on any edge where ev_valid and ev_ready are both high.
interface trace_event_sampler_if
  import trace_event_sampler_pkg::*;
#(
  parameter int TS_W = 17
);

  logic                ev_valid;
  logic                ev_ready;
  logic [EV_VEC_W-1:0] ev_vec;
  logic [TS_W-1:0]     ev_time;

  modport master (
    output ev_valid,
    output ev_vec,
    output ev_time,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_vec,
    input  ev_time,
    output ev_ready
  );

endinterface

// File: rtl/trace_evsamp_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as 0 when empty.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module trace_evsamp_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [AW:0]  count;
  logic         do_push, do_pop;

  assign count   = wptr_q - rptr_q;
  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wptr_d  = wptr_q + (AW+1)'(do_push);
  assign rptr_d  = rptr_q + (AW+1)'(do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/trace_event_sampler.sv
// Synchronises and debounces {i4,i3,i2,i1}, queueing each accepted change with a timestamp.
// TRACE_EVSAMP_INITIAL_EVENT_EN: also queue the settled starting vector once after reset, at time 0.
module trace_event_sampler
  import trace_event_sampler_pkg::*;
#(
  parameter int TS_W       = 17,
  parameter int DEPTH      = 8,
  parameter int STABLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i1,
  input  logic                   i2,
  input  logic                   i3,
  input  logic                   i4,
  trace_event_sampler_if.master  ev,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int SW = $clog2(STABLE_CYC + 1) + 1;
  localparam int EW = ev_w(TS_W);

  logic [EV_VEC_W-1:0] raw;
  logic [EV_VEC_W-1:0] s1_q, s2_q;
  logic [EV_VEC_W-1:0] acc_q, acc_d;
  logic [EV_VEC_W-1:0] cand_q, cand_d;
  logic [SW-1:0]       stab_q, stab_d, stab_inc;
  logic [TS_W-1:0]     ts_q, push_ts;
  logic                ovf_q, ovf_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                push, pop, full, empty;
  logic [EW-1:0]       head;

`ifdef TRACE_EVSAMP_INITIAL_EVENT_EN
  logic [1:0] boot_q, boot_d;
`endif

  assign raw = {i4, i3, i2, i1};
  assign pop = ev.ev_valid && ev.ev_ready;

  always_comb begin
    acc_d    = acc_q;
    cand_d   = cand_q;
    stab_d   = '0;
    push     = 1'b0;
    push_ts  = ts_q;
    stab_inc = (s2_q == cand_q) ? stab_q + SW'(1) : SW'(1);
    if (s2_q != acc_q) begin
      cand_d = s2_q;
      if (stab_inc >= SW'(STABLE_CYC)) begin
        push  = 1'b1;
        acc_d = s2_q;
      end else begin
        stab_d = stab_inc;
      end
    end
`ifdef TRACE_EVSAMP_INITIAL_EVENT_EN
    // Wait until the synchroniser holds real input before announcing it.
    boot_d = (boot_q == 2'd3) ? boot_q : boot_q + 2'd1;
    if (boot_q == 2'd2) begin
      push    = 1'b1;
      push_ts = '0;
      acc_d   = s2_q;
      cand_d  = s2_q;
      stab_d  = '0;
    end
`endif
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (push && full && !pop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      acc_q  <= '0;
      cand_q <= '0;
      stab_q <= '0;
      ts_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      acc_q  <= acc_d;
      cand_q <= cand_d;
      stab_q <= stab_d;
      ts_q   <= ts_q + TS_W'(1);
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

`ifdef TRACE_EVSAMP_INITIAL_EVENT_EN
  always_ff @(posedge clk) begin
    if (reset) boot_q <= '0;
    else       boot_q <= boot_d;
  end
`endif

  trace_evsamp_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({push_ts, s2_q}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ev.ev_valid = !empty;
  assign {ev.ev_time, ev.ev_vec} = head;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule
